// File: rtl/phase_uart_tx.sv
// Phase-record FIFO feeding a UART 8N1 serializer: each record leaves as an
// 8-byte packet (sync, freq, phaseA, phaseB, XOR checksum of bytes 1..6).
module phase_uart_tx #(
   parameter int unsigned FFT    = 11,
   parameter int unsigned DEPTH  = 16,
   parameter int unsigned CLK_HZ = 100000000,
   parameter int unsigned BAUD   = 921600
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           sink_valid,
   input  logic           sink_sop,
   input  logic           sink_eop,
   input  logic [FFT-1:0] sink_freq,
   input  logic [15:0]    sink_phaseA,
   input  logic [15:0]    sink_phaseB,
   output logic           sink_ready,
   output logic           tx,
   output logic           busy,
   output logic           overflow
);
   localparam int unsigned DIV = CLK_HZ / BAUD;
   localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int unsigned AW  = $clog2(DEPTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

   typedef enum logic [2:0] {IDLE, LOAD, START, DATA, STOP} state_t;

   state_t        state;
   logic [49:0]   mem [DEPTH];
   logic [AW:0]   wptr, rptr, wptr_n, rptr_n;
   logic          empty, wr, pop, bit_end;
   logic [CW-1:0] cnt;
   logic [2:0]    bitidx, byteidx;
   logic [7:0]    txbyte;
   logic [55:0]   pkt;
   logic [49:0]   rd;
   logic [7:0]    sync, chk;

   assign empty   = (wptr == rptr);
   assign wr      = sink_valid && sink_ready;
   assign bit_end = (cnt == CNT_LAST);
   assign pop     = (state == LOAD) ||
                    (state == STOP && bit_end && byteidx == 3'd7 && !empty);
   assign wptr_n  = wptr + {{AW{1'b0}}, wr};
   assign rptr_n  = rptr + {{AW{1'b0}}, pop};
   assign busy    = (state != IDLE) || !empty;

   // head record: {eop, sop, freq[15:0], phaseA, phaseB}
   assign rd   = mem[rptr[AW-1:0]];
   assign sync = {6'b101001, rd[49], rd[48]};
   assign chk  = rd[47:40] ^ rd[39:32] ^ rd[31:24] ^ rd[23:16] ^ rd[15:8] ^ rd[7:0];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wptr       <= '0;
         rptr       <= '0;
         sink_ready <= 1'b1;
         overflow   <= 1'b0;
      end else begin
         wptr       <= wptr_n;
         rptr       <= rptr_n;
         sink_ready <= !((wptr_n[AW] != rptr_n[AW]) &&
                         (wptr_n[AW-1:0] == rptr_n[AW-1:0]));
         if (sink_valid && !sink_ready)
            overflow <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (wr)
         mem[wptr[AW-1:0]] <= {sink_eop, sink_sop, 16'(sink_freq), sink_phaseA, sink_phaseB};
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         tx      <= 1'b1;
         cnt     <= '0;
         bitidx  <= '0;
         byteidx <= '0;
         txbyte  <= '0;
         pkt     <= '0;
      end else begin
         case (state)
            IDLE: begin
               tx <= 1'b1;
               if (!empty)
                  state <= LOAD;
            end
            LOAD: begin
               txbyte  <= sync;
               pkt     <= {rd[47:0], chk};
               byteidx <= '0;
               cnt     <= '0;
               tx      <= 1'b0;
               state   <= START;
            end
            START: begin
               if (bit_end) begin
                  cnt    <= '0;
                  bitidx <= '0;
                  tx     <= txbyte[0];
                  txbyte <= {1'b0, txbyte[7:1]};
                  state  <= DATA;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DATA: begin
               if (bit_end) begin
                  cnt <= '0;
                  if (bitidx == 3'd7) begin
                     tx    <= 1'b1;
                     state <= STOP;
                  end else begin
                     bitidx <= bitidx + 1'b1;
                     tx     <= txbyte[0];
                     txbyte <= {1'b0, txbyte[7:1]};
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            STOP: begin
               if (bit_end) begin
                  cnt <= '0;
                  if (byteidx != 3'd7) begin
                     byteidx <= byteidx + 1'b1;
                     txbyte  <= pkt[55:48];
                     pkt     <= {pkt[47:0], 8'h00};
                     tx      <= 1'b0;
                     state   <= START;
                  end else if (!empty) begin
                     // the load of the next packet shares the last stop clock,
                     // so back-to-back packets have no idle gap
                     txbyte  <= sync;
                     pkt     <= {rd[47:0], chk};
                     byteidx <= '0;
                     tx      <= 1'b0;
                     state   <= START;
                  end else begin
                     state <= IDLE;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_phase_uart_tx.sv
// Directed bench for phase_uart_tx: decodes tx with a UART receiver model and
// compares bytes, timing and flags against hand-computed expectations (DIV=10).
module tb_phase_uart_tx;
   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        sink_valid = 1'b0, sink_sop = 1'b0, sink_eop = 1'b0;
   logic [10:0] sink_freq = '0;
   logic [15:0] sink_phaseA = '0, sink_phaseB = '0;
   logic        sink_ready, tx, busy, overflow;

   phase_uart_tx #(.FFT(11), .DEPTH(16), .CLK_HZ(1000), .BAUD(100)) dut (
      .clk(clk), .reset(reset), .sink_valid(sink_valid), .sink_sop(sink_sop),
      .sink_eop(sink_eop), .sink_freq(sink_freq), .sink_phaseA(sink_phaseA),
      .sink_phaseB(sink_phaseB), .sink_ready(sink_ready), .tx(tx), .busy(busy),
      .overflow(overflow)
   );

   always #5 clk = ~clk;

   int         cyc = 0;
   int         n_chk = 0, n_pass = 0;
   int         frame_err = 0;
   int         last_wr = 0;
   logic [7:0] rx_q[$];
   int         fall_q[$];
   logic [7:0] exp_q[$];

   always @(posedge clk) cyc++;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp)
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      else
         n_pass++;
   endtask

   // receiver model: samples mid-bit on negedges, abandons a byte on reset
   initial begin : rx_mon
      logic [7:0] b;
      int         f;
      bit         ok;
      forever begin
         @(negedge clk);
         if (reset && tx === 1'b0) begin
            f  = cyc;
            ok = 1'b1;
            b  = '0;
            for (int k = 1; k < 100 && ok; k++) begin
               @(negedge clk);
               if (!reset) ok = 1'b0;
               else if (k == 5) begin
                  if (tx !== 1'b0) frame_err++;
               end else if (k >= 15 && k <= 85 && (k % 10) == 5)
                  b[3'((k - 15) / 10)] = tx;
               else if (k == 95) begin
                  if (tx !== 1'b1) frame_err++;
               end
            end
            if (ok) begin
               rx_q.push_back(b);
               fall_q.push_back(f);
            end
         end
      end
   end

   task automatic drive(input logic s, input logic e, input logic [10:0] f,
                        input logic [15:0] a, input logic [15:0] b, output logic rdy);
      sink_valid = 1'b1; sink_sop = s; sink_eop = e;
      sink_freq = f; sink_phaseA = a; sink_phaseB = b;
      rdy = sink_ready;
      @(negedge clk);
      last_wr = cyc;
   endtask

   task automatic push_exp(input logic s, input logic e, input logic [10:0] f,
                           input logic [15:0] a, input logic [15:0] b);
      logic [15:0] fz;
      fz = {5'b0, f};
      exp_q.push_back(8'hA4 | {6'b0, e, s});
      exp_q.push_back(fz[15:8]); exp_q.push_back(fz[7:0]);
      exp_q.push_back(a[15:8]);  exp_q.push_back(a[7:0]);
      exp_q.push_back(b[15:8]);  exp_q.push_back(b[7:0]);
      exp_q.push_back(fz[15:8] ^ fz[7:0] ^ a[15:8] ^ a[7:0] ^ b[15:8] ^ b[7:0]);
   endtask

   task automatic compare_rx(input string tag);
      int n;
      check({tag, "_nbytes"}, rx_q.size(), exp_q.size());
      n = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
      for (int i = 0; i < n; i++)
         check($sformatf("%s_b%0d", tag, i), rx_q[i], exp_q[i]);
      rx_q.delete(); fall_q.delete(); exp_q.delete();
   endtask

   task automatic wait_fall(input string tag, output int f);
      int i;
      for (i = 0; i < 200 && tx !== 1'b0; i++) @(negedge clk);
      check({tag, "_fall_seen"}, tx, 1'b0);
      f = cyc;
   endtask

   task automatic wait_idle(input string tag, input int bound);
      int i;
      for (i = 0; i < bound && busy !== 1'b0; i++) @(negedge clk);
      check({tag, "_idle"}, busy, 1'b0);
      repeat (3) @(negedge clk);
   endtask

   initial begin
      logic        r;
      int          f0;
      logic [15:0] a;
      bit          tx_ok, busy_ok, rdy_ok;

      repeat (5) @(negedge clk);
      check("rst_tx", tx, 1'b1);
      check("rst_busy", busy, 1'b0);
      check("rst_ovf", overflow, 1'b0);
      check("rst_ready", sink_ready, 1'b1);
      reset = 1'b1;
      repeat (2) @(negedge clk);

      // single record: A5 00 05 20 00 E0 00 C5
      drive(1'b1, 1'b0, 11'd5, 16'h2000, 16'hE000, r);
      sink_valid = 1'b0;
      check("s1_busy_after_wr", busy, 1'b1);
      wait_fall("s1", f0);
      check("s1_latency", f0 - last_wr, 2);
      while (cyc < f0 + 799) @(negedge clk);
      check("s1_busy_last_stop", busy, 1'b1);
      @(negedge clk);
      check("s1_busy_done", busy, 1'b0);
      repeat (3) @(negedge clk);
      check("s1_span", (fall_q.size() == 8) ? fall_q[7] - fall_q[0] : -1, 700);
      exp_q = '{8'hA5, 8'h00, 8'h05, 8'h20, 8'h00, 8'hE0, 8'h00, 8'hC5};
      compare_rx("s1");

      // three back-to-back records: sop, middle, eop
      drive(1'b1, 1'b0, 11'd100, 16'h1234, 16'h5678, r);
      drive(1'b0, 1'b0, 11'd101, 16'h9ABC, 16'hDEF0, r);
      drive(1'b0, 1'b1, 11'd102, 16'h0F0F, 16'hF00F, r);
      sink_valid = 1'b0;
      push_exp(1'b1, 1'b0, 11'd100, 16'h1234, 16'h5678);
      push_exp(1'b0, 1'b0, 11'd101, 16'h9ABC, 16'hDEF0);
      push_exp(1'b0, 1'b1, 11'd102, 16'h0F0F, 16'hF00F);
      wait_idle("s3", 5000);
      check("s3_span", (fall_q.size() == 24) ? fall_q[23] - fall_q[0] : -1, 2300);
      compare_rx("s3");

      // overflow: line busy with R0, then DEPTH+1 consecutive writes
      drive(1'b0, 1'b0, 11'd7, 16'h4444, 16'h5555, r);
      sink_valid = 1'b0;
      push_exp(1'b0, 1'b0, 11'd7, 16'h4444, 16'h5555);
      wait_fall("s4", f0);
      for (int i = 0; i < 17; i++) begin
         a = 16'(i * 16'h1111);
         if (i == 16) check("s4_ovf_before_drop", overflow, 1'b0);
         drive(i == 0, i == 15, 11'(i * 37 + 1), a, a ^ 16'hF0F0, r);
         if (i == 15) check("s4_ready_before_16th", r, 1'b1);
         if (i == 16) check("s4_ready_before_17th", r, 1'b0);
         if (i < 16) push_exp(i == 0, i == 15, 11'(i * 37 + 1), a, a ^ 16'hF0F0);
      end
      sink_valid = 1'b0;
      check("s4_ovf_set", overflow, 1'b1);
      check("s4_ready_low", sink_ready, 1'b0);
      wait_idle("s4", 20000);
      check("s4_ovf_sticky", overflow, 1'b1);
      check("s4_ready_drained", sink_ready, 1'b1);
      compare_rx("s4");

      // extreme field values; checksum 07^FF^80^00^7F^FF = F8
      drive(1'b0, 1'b0, 11'h7FF, 16'h8000, 16'h7FFF, r);
      sink_valid = 1'b0;
      wait_idle("s5", 2000);
      exp_q = '{8'hA4, 8'h07, 8'hFF, 8'h80, 8'h00, 8'h7F, 8'hFF, 8'hF8};
      compare_rx("s5");

      // reset during data bit 3 of B3 (phaseA high byte = 00, so tx is low)
      drive(1'b0, 1'b1, 11'd3, 16'h0012, 16'hABCD, r);
      sink_valid = 1'b0;
      wait_fall("s6", f0);
      while (cyc < f0 + 345) @(negedge clk);
      check("s6_tx_low_pre", tx, 1'b0);
      #2 reset = 1'b0;
      #1;
      check("s6_tx_async", tx, 1'b1);
      check("s6_busy", busy, 1'b0);
      check("s6_ovf", overflow, 1'b0);
      check("s6_ready", sink_ready, 1'b1);
      repeat (3) @(negedge clk);
      rx_q.delete(); fall_q.delete(); exp_q.delete();
      reset = 1'b1;
      repeat (300) @(negedge clk);
      check("s6_no_resume", rx_q.size(), 0);
      check("s6_busy_quiet", busy, 1'b0);
      drive(1'b1, 1'b1, 11'd42, 16'hCAFE, 16'hBEEF, r);
      sink_valid = 1'b0;
      push_exp(1'b1, 1'b1, 11'd42, 16'hCAFE, 16'hBEEF);
      wait_idle("s6", 2000);
      compare_rx("s6");

      // idle line after a fresh reset
      @(negedge clk) reset = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      tx_ok = 1'b1; busy_ok = 1'b1; rdy_ok = 1'b1;
      repeat (10000) begin
         @(negedge clk);
         if (tx !== 1'b1) tx_ok = 1'b0;
         if (busy !== 1'b0) busy_ok = 1'b0;
         if (sink_ready !== 1'b1) rdy_ok = 1'b0;
      end
      check("s7_tx_high", tx_ok, 1'b1);
      check("s7_busy_low", busy_ok, 1'b1);
      check("s7_ready_high", rdy_ok, 1'b1);
      check("s7_no_bytes", rx_q.size(), 0);

      check("frame_errors", frame_err, 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
